// File: rtl/core_hazard_unit_pkg.sv
// Shared types and constants for the core hazard unit.
//   haz_state_t : stall FSM state (RUN / I_WAIT / D_WAIT)
//   BP_*        : operand bypass select encodings
//   REG_*       : indices into the per-register enable/kill buses
package core_haz_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } haz_state_t;

  localparam logic [1:0] BP_REG = 2'b00;
  localparam logic [1:0] BP_MEM = 2'b01;
  localparam logic [1:0] BP_WB  = 2'b10;

  localparam int REG_IF_DEC  = 0;
  localparam int REG_DEC_EXE = 1;
  localparam int REG_EXE_MEM = 2;
  localparam int REG_MEM_WB  = 3;

endpackage

// File: rtl/core_hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : hazard unit side (consumes pipeline status, drives controls)
//   slave  : pipeline side (drives status, consumes controls)
// Status : DEC/EXE/MEM/WB register addresses and write enables, branch
//          resolution, L1I/L1D request/ack.
// Control: enable/kill buses, PC stop, NOP insert, PC transfer select,
//          bypass selects, watchdog flag.
interface core_hazard_unit_if #(
  parameter int RA_W      = 5,
  parameter int PIPE_REGS = 4
);
  logic [RA_W-1:0]      dec_rs1;
  logic [RA_W-1:0]      dec_rs2;
  logic                 dec_rs1_used;
  logic                 dec_rs2_used;
  logic [RA_W-1:0]      exe_rs1;
  logic [RA_W-1:0]      exe_rs2;
  logic [RA_W-1:0]      exe_rd;
  logic                 exe_we;
  logic                 exe_is_load;
  logic                 exe_brnch_tkn;
  logic [RA_W-1:0]      mem_rd;
  logic                 mem_we;
  logic [RA_W-1:0]      mem_rs2;
  logic [RA_W-1:0]      wb_rd;
  logic                 wb_we;
  logic                 l1i_req_val;
  logic                 l1i_ack;
  logic                 l1d_req_val;
  logic                 l1d_ack;
  logic [PIPE_REGS-1:0] haz_enb_bus;
  logic [PIPE_REGS-1:0] haz_kill_bus;
  logic                 haz_pc_stop;
  logic                 haz_nop_gen;
  logic                 haz_mux_trn;
  logic [3:0]           haz_bp_mux_exe;
  logic                 haz_bp_mux_mem;
  logic                 haz_timeout;

  modport master (
    input  dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
    input  exe_rs1, exe_rs2, exe_rd, exe_we, exe_is_load, exe_brnch_tkn,
    input  mem_rd, mem_we, mem_rs2, wb_rd, wb_we,
    input  l1i_req_val, l1i_ack, l1d_req_val, l1d_ack,
    output haz_enb_bus, haz_kill_bus, haz_pc_stop, haz_nop_gen, haz_mux_trn,
    output haz_bp_mux_exe, haz_bp_mux_mem, haz_timeout
  );

  modport slave (
    output dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
    output exe_rs1, exe_rs2, exe_rd, exe_we, exe_is_load, exe_brnch_tkn,
    output mem_rd, mem_we, mem_rs2, wb_rd, wb_we,
    output l1i_req_val, l1i_ack, l1d_req_val, l1d_ack,
    input  haz_enb_bus, haz_kill_bus, haz_pc_stop, haz_nop_gen, haz_mux_trn,
    input  haz_bp_mux_exe, haz_bp_mux_mem, haz_timeout
  );
endinterface

// File: rtl/core_hazard_unit_fwd_sel.sv
// Bypass select for one EXE source operand.
//   src            : operand register address
//   mem_rd, mem_we : MEM-stage destination / write enable
//   wb_rd, wb_we   : WB-stage destination / write enable
//   sel            : BP_MEM, BP_WB or BP_REG (MEM wins over WB, x0 never forwards)
module core_haz_fwd_sel
  import core_haz_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_we,
  output logic [1:0]      sel
);

  always_comb begin
    sel = BP_REG;
    if (wb_we && (wb_rd != '0) && (src == wb_rd)) sel = BP_WB;
    if (mem_we && (mem_rd != '0) && (src == mem_rd)) sel = BP_MEM;
  end

endmodule

// File: rtl/core_hazard_unit.sv
// Hazard, forwarding and stall controller for the IF/DEC/EXE/MEM/WB pipeline.
//   clk, rst_n : clock, async active-low reset
//   hz         : core_hazard_unit_if.master (pipeline status in, controls out)
// Optional feature: define CORE_HAZ_TIMEOUT_EN to build the L1 wait watchdog;
// otherwise haz_timeout is tied low.
//
// state  | meaning
// RUN    | no outstanding L1 miss being waited on
// I_WAIT | fetch outstanding, PC held, bubbles into IF/DEC
// D_WAIT | data access outstanding, whole pipe frozen
module core_hazard_unit
  import core_haz_pkg::*;
#(
  parameter int RA_W      = 5,
  parameter int PIPE_REGS = 4,
  parameter int WAIT_MAX  = 255
) (
  input logic               clk,
  input logic               rst_n,
  core_hazard_unit_if.master hz
);

  if (PIPE_REGS < 4 || WAIT_MAX < 1) begin : g_bad_cfg
    $error("core_hazard_unit: PIPE_REGS must be >= 4 and WAIT_MAX >= 1");
  end

  haz_state_t state, state_nxt;
  logic       drop_pending;

  logic d_cond, i_cond, freeze, fetch_wait, load_use, branch;
  logic [1:0] sel_rs1, sel_rs2;

  logic [PIPE_REGS-1:0] enb, kill;
  logic pc_stop, nop_gen, mux_trn;

  core_haz_fwd_sel #(.RA_W(RA_W)) u_fwd_rs1 (
    .src(hz.exe_rs1), .mem_rd(hz.mem_rd), .mem_we(hz.mem_we),
    .wb_rd(hz.wb_rd), .wb_we(hz.wb_we), .sel(sel_rs1)
  );

  core_haz_fwd_sel #(.RA_W(RA_W)) u_fwd_rs2 (
    .src(hz.exe_rs2), .mem_rd(hz.mem_rd), .mem_we(hz.mem_we),
    .wb_rd(hz.wb_rd), .wb_we(hz.wb_we), .sel(sel_rs2)
  );

  assign d_cond = hz.l1d_req_val & ~hz.l1d_ack;
  assign i_cond = hz.l1i_req_val & ~hz.l1i_ack;

  // A data miss takes precedence over a fetch miss from any non-D state.
  assign freeze     = (state == D_WAIT) ? ~hz.l1d_ack : d_cond;
  assign fetch_wait = ~d_cond & (((state == I_WAIT) & ~hz.l1i_ack) |
                                 ((state == RUN) & i_cond));

  assign load_use = hz.exe_is_load & hz.exe_we & (hz.exe_rd != '0) &
                    ((hz.dec_rs1_used & (hz.dec_rs1 == hz.exe_rd)) |
                     (hz.dec_rs2_used & (hz.dec_rs2 == hz.exe_rd)));
  assign branch   = hz.exe_brnch_tkn;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (d_cond) state_nxt = D_WAIT;
               else if (i_cond) state_nxt = I_WAIT;
      I_WAIT:  if (d_cond) state_nxt = D_WAIT;
               else if (hz.l1i_ack) state_nxt = RUN;
      D_WAIT:  if (hz.l1d_ack) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      drop_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      // Any fetch response retires the discard, whether or not it was applied.
      if (hz.l1i_ack) drop_pending <= 1'b0;
      else if (branch && fetch_wait) drop_pending <= 1'b1;
    end
  end

  always_comb begin
    enb     = '1;
    kill    = '0;
    pc_stop = 1'b0;
    nop_gen = 1'b0;
    mux_trn = 1'b0;
    if (!rst_n) begin
      kill    = '1;
      pc_stop = 1'b1;
    end else if (freeze) begin
      enb     = '0;
      pc_stop = 1'b1;
    end else begin
      if (fetch_wait) begin
        pc_stop          = 1'b1;
        kill[REG_IF_DEC] = 1'b1;
      end
      if (drop_pending && hz.l1i_ack) kill[REG_IF_DEC] = 1'b1;
      // Load-use holds IF/DEC, so it must not be killed in the same cycle.
      if (load_use && !branch) begin
        pc_stop          = 1'b1;
        enb[REG_IF_DEC]  = 1'b0;
        kill[REG_IF_DEC] = 1'b0;
        nop_gen          = 1'b1;
      end
      if (branch) begin
        mux_trn                         = 1'b1;
        pc_stop                         = 1'b0;
        kill[REG_DEC_EXE:REG_IF_DEC]    = 2'b11;
      end
    end
  end

  assign hz.haz_enb_bus    = enb;
  assign hz.haz_kill_bus   = kill;
  assign hz.haz_pc_stop    = pc_stop;
  assign hz.haz_nop_gen    = nop_gen;
  assign hz.haz_mux_trn    = mux_trn;
  assign hz.haz_bp_mux_exe = rst_n ? {sel_rs2, sel_rs1} : 4'b0000;
  assign hz.haz_bp_mux_mem = rst_n & hz.wb_we & (hz.wb_rd != '0) &
                             (hz.wb_rd == hz.mem_rs2);

`ifdef CORE_HAZ_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_nxt == RUN) wait_cnt <= '0;
      else if (state != RUN && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
      if (wait_cnt == CNT_MAX) timeout_q <= 1'b1;
    end
  end

  assign hz.haz_timeout = timeout_q;
`else
  assign hz.haz_timeout = 1'b0;
`endif

endmodule
